// File: rtl/rvga_dmem_bridge.sv
// Data-memory bridge: turns the core's level-held dmem request into one valid/ready bus transaction.
// Optional WAIT-state timeout with sticky err_o is enabled by defining RVGA_DMEM_TIMEOUT_EN.
module rvga_dmem_bridge #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              dmem_r_v_i,
    input  logic              dmem_w_v_i,
    input  logic [ADDR_W-1:0] dmem_addr_i,
    input  logic [DATA_W-1:0] dmem_wdata_i,
    output logic [DATA_W-1:0] dmem_rdata_o,
    output logic              dmem_resp_v_o,
    output logic              bus_req_v_o,
    input  logic              bus_req_ready_i,
    output logic              bus_we_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [DATA_W-1:0] bus_wdata_o,
    input  logic              bus_resp_v_i,
    input  logic [DATA_W-1:0] bus_rdata_i,
    output logic              err_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("rvga_dmem_bridge: TIMEOUT_CYCLES must be in 1..255");
    end

    state_t state;

`ifdef RVGA_DMEM_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] wait_cnt;
    logic       err_q;
    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state         <= S_IDLE;
            bus_req_v_o   <= 1'b0;
            bus_we_o      <= 1'b0;
            bus_addr_o    <= '0;
            bus_wdata_o   <= '0;
            dmem_rdata_o  <= '0;
            dmem_resp_v_o <= 1'b0;
`ifdef RVGA_DMEM_TIMEOUT_EN
            wait_cnt      <= '0;
            err_q         <= 1'b0;
`endif
        end else begin
            dmem_resp_v_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    // Write wins when the core raises both request strobes.
                    if (dmem_r_v_i || dmem_w_v_i) begin
                        bus_we_o    <= dmem_w_v_i;
                        bus_addr_o  <= dmem_addr_i & WORD_MASK;
                        bus_wdata_o <= dmem_wdata_i;
                        bus_req_v_o <= 1'b1;
                        state       <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (bus_req_ready_i) begin
                        bus_req_v_o <= 1'b0;
                        state       <= S_WAIT;
`ifdef RVGA_DMEM_TIMEOUT_EN
                        wait_cnt    <= '0;
`endif
                    end
                end
                S_WAIT: begin
                    if (bus_resp_v_i) begin
                        if (!bus_we_o) begin
                            dmem_rdata_o <= bus_rdata_i;
                        end
                        dmem_resp_v_o <= 1'b1;
                        state         <= S_DONE;
                    end
`ifdef RVGA_DMEM_TIMEOUT_EN
                    else if (wait_cnt == TIMEOUT_LAST) begin
                        dmem_rdata_o  <= DATA_W'(32'hDEADBEEF);
                        dmem_resp_v_o <= 1'b1;
                        err_q         <= 1'b1;
                        state         <= S_DONE;
                    end else if (wait_cnt != 8'hFF) begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
`endif
                end
                S_DONE: begin
                    // Core request is still visible here; it is only re-sampled from IDLE.
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rvga_dmem_bridge.sv
// Directed bench for rvga_dmem_bridge: read, stalled write, back-to-back reads, r/w priority,
// async reset with stale response, and (with RVGA_DMEM_TIMEOUT_EN) the WAIT timeout.
module tb_rvga_dmem_bridge;

    logic        clk = 1'b0;
    logic        rst_i = 1'b0;
    logic        dmem_r_v_i = 1'b0;
    logic        dmem_w_v_i = 1'b0;
    logic [31:0] dmem_addr_i = '0;
    logic [31:0] dmem_wdata_i = '0;
    logic [31:0] dmem_rdata_o;
    logic        dmem_resp_v_o;
    logic        bus_req_v_o;
    logic        bus_req_ready_i = 1'b0;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_wdata_o;
    logic        bus_resp_v_i = 1'b0;
    logic [31:0] bus_rdata_i = '0;
    logic        err_o;

    int checks = 0;
    int errors = 0;
    int hs_cnt = 0;
    int hs_base;

    rvga_dmem_bridge #(
        .ADDR_W(32),
        .DATA_W(32),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk_i(clk),
        .rst_i(rst_i),
        .dmem_r_v_i(dmem_r_v_i),
        .dmem_w_v_i(dmem_w_v_i),
        .dmem_addr_i(dmem_addr_i),
        .dmem_wdata_i(dmem_wdata_i),
        .dmem_rdata_o(dmem_rdata_o),
        .dmem_resp_v_o(dmem_resp_v_o),
        .bus_req_v_o(bus_req_v_o),
        .bus_req_ready_i(bus_req_ready_i),
        .bus_we_o(bus_we_o),
        .bus_addr_o(bus_addr_o),
        .bus_wdata_o(bus_wdata_o),
        .bus_resp_v_i(bus_resp_v_i),
        .bus_rdata_i(bus_rdata_i),
        .err_o(err_o)
    );

    always #5 clk = ~clk;

    // Counts accepted bus requests (valid & ready at a rising edge).
    always @(posedge clk) begin
        if (bus_req_v_o === 1'b1 && bus_req_ready_i === 1'b1) hs_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset state
        step();
        step();
        check("rst_req_v", 32'(bus_req_v_o), 32'd0);
        check("rst_resp_v", 32'(dmem_resp_v_o), 32'd0);
        check("rst_rdata", dmem_rdata_o, 32'h0);
        check("rst_addr", bus_addr_o, 32'h0);
        check("rst_err", 32'(err_o), 32'd0);
        rst_i = 1'b1;
        step();

        // 1: read 0x100, ready at once, response on the second WAIT cycle
        hs_base = hs_cnt;
        dmem_r_v_i = 1'b1; dmem_addr_i = 32'h100;
        step();
        check("t1_req_v", 32'(bus_req_v_o), 32'd1);
        check("t1_addr", bus_addr_o, 32'h100);
        check("t1_we", 32'(bus_we_o), 32'd0);
        bus_req_ready_i = 1'b1;
        step();
        bus_req_ready_i = 1'b0;
        check("t1_req_v_drop", 32'(bus_req_v_o), 32'd0);
        step();
        check("t1_no_early_resp", 32'(dmem_resp_v_o), 32'd0);
        bus_resp_v_i = 1'b1; bus_rdata_i = 32'h12345678;
        step();
        bus_resp_v_i = 1'b0; dmem_r_v_i = 1'b0;
        check("t1_resp_v", 32'(dmem_resp_v_o), 32'd1);
        check("t1_rdata", dmem_rdata_o, 32'h12345678);
        step();
        check("t1_resp_pulse_end", 32'(dmem_resp_v_o), 32'd0);
        check("t1_rdata_held", dmem_rdata_o, 32'h12345678);
        check("t1_beats", 32'(hs_cnt - hs_base), 32'd1);

        // 2: write 0xCAFEF00D to 0x203, ready low for 5 cycles
        dmem_w_v_i = 1'b1; dmem_addr_i = 32'h203; dmem_wdata_i = 32'hCAFEF00D;
        step();
        for (int i = 0; i < 5; i++) begin
            check("t2_req_v_held", 32'(bus_req_v_o), 32'd1);
            check("t2_addr_stable", bus_addr_o, 32'h200);
            check("t2_wdata_stable", bus_wdata_o, 32'hCAFEF00D);
            check("t2_we", 32'(bus_we_o), 32'd1);
            step();
        end
        check("t2_req_v_6th", 32'(bus_req_v_o), 32'd1);
        bus_req_ready_i = 1'b1;
        step();
        bus_req_ready_i = 1'b0;
        check("t2_req_v_drop", 32'(bus_req_v_o), 32'd0);
        bus_resp_v_i = 1'b1; bus_rdata_i = 32'h55555555;
        step();
        bus_resp_v_i = 1'b0; dmem_w_v_i = 1'b0;
        check("t2_resp_v", 32'(dmem_resp_v_o), 32'd1);
        check("t2_rdata_unchanged", dmem_rdata_o, 32'h12345678);
        step();
        check("t2_resp_pulse_end", 32'(dmem_resp_v_o), 32'd0);

        // 3: back-to-back reads 0x10 then 0x14, request held through DONE
        hs_base = hs_cnt;
        dmem_r_v_i = 1'b1; dmem_addr_i = 32'h10; bus_req_ready_i = 1'b1;
        step();
        check("t3_addr0", bus_addr_o, 32'h10);
        step();
        bus_resp_v_i = 1'b1; bus_rdata_i = 32'h11111111;
        step();
        bus_resp_v_i = 1'b0;
        check("t3_resp0", 32'(dmem_resp_v_o), 32'd1);
        check("t3_rdata0", dmem_rdata_o, 32'h11111111);
        dmem_addr_i = 32'h14;
        step();
        check("t3_gap_req_v", 32'(bus_req_v_o), 32'd0);
        check("t3_gap_resp_v", 32'(dmem_resp_v_o), 32'd0);
        step();
        check("t3_req_v1", 32'(bus_req_v_o), 32'd1);
        check("t3_addr1", bus_addr_o, 32'h14);
        step();
        bus_resp_v_i = 1'b1; bus_rdata_i = 32'h22222222;
        step();
        bus_resp_v_i = 1'b0; dmem_r_v_i = 1'b0;
        check("t3_resp1", 32'(dmem_resp_v_o), 32'd1);
        check("t3_rdata1", dmem_rdata_o, 32'h22222222);
        step();
        step();
        bus_req_ready_i = 1'b0;
        check("t3_beats", 32'(hs_cnt - hs_base), 32'd2);
        check("t3_idle_req_v", 32'(bus_req_v_o), 32'd0);

        // 4: spurious response in IDLE, then simultaneous r_v and w_v
        bus_resp_v_i = 1'b1; bus_rdata_i = 32'h77777777;
        step();
        bus_resp_v_i = 1'b0;
        check("t4_spurious_resp", 32'(dmem_resp_v_o), 32'd0);
        step();
        check("t4_spurious_resp2", 32'(dmem_resp_v_o), 32'd0);
        check("t4_spurious_rdata", dmem_rdata_o, 32'h22222222);
        dmem_r_v_i = 1'b1; dmem_w_v_i = 1'b1; dmem_addr_i = 32'h40; dmem_wdata_i = 32'h0BADF00D;
        step();
        check("t4_we_priority", 32'(bus_we_o), 32'd1);
        check("t4_wdata", bus_wdata_o, 32'h0BADF00D);
        bus_req_ready_i = 1'b1;
        step();
        bus_req_ready_i = 1'b0; bus_resp_v_i = 1'b1;
        step();
        bus_resp_v_i = 1'b0; dmem_r_v_i = 1'b0; dmem_w_v_i = 1'b0;
        check("t4_resp_v", 32'(dmem_resp_v_o), 32'd1);
        check("t4_rdata_unchanged", dmem_rdata_o, 32'h22222222);
        step();

        // 5: asynchronous reset during WAIT, stale response after release
        dmem_r_v_i = 1'b1; dmem_addr_i = 32'h80; bus_req_ready_i = 1'b1;
        step();
        step();
        bus_req_ready_i = 1'b0; dmem_r_v_i = 1'b0;
        #2 rst_i = 1'b0;
        #1;
        check("t5_async_req_v", 32'(bus_req_v_o), 32'd0);
        check("t5_async_rdata", dmem_rdata_o, 32'h0);
        check("t5_async_addr", bus_addr_o, 32'h0);
        step();
        rst_i = 1'b1;
        bus_resp_v_i = 1'b1; bus_rdata_i = 32'h99999999;
        step();
        check("t5_stale_resp", 32'(dmem_resp_v_o), 32'd0);
        step();
        bus_resp_v_i = 1'b0;
        check("t5_stale_resp2", 32'(dmem_resp_v_o), 32'd0);
        check("t5_stale_rdata", dmem_rdata_o, 32'h0);
        dmem_r_v_i = 1'b1; dmem_addr_i = 32'h84; bus_req_ready_i = 1'b1;
        step();
        check("t5_req_v", 32'(bus_req_v_o), 32'd1);
        check("t5_addr", bus_addr_o, 32'h84);
        step();
        bus_req_ready_i = 1'b0; bus_resp_v_i = 1'b1; bus_rdata_i = 32'h0F0F0F0F;
        step();
        bus_resp_v_i = 1'b0; dmem_r_v_i = 1'b0;
        check("t5_resp_v", 32'(dmem_resp_v_o), 32'd1);
        check("t5_rdata", dmem_rdata_o, 32'h0F0F0F0F);
        step();

`ifdef RVGA_DMEM_TIMEOUT_EN
        // 6: read with no response times out after 8 WAIT cycles
        dmem_r_v_i = 1'b1; dmem_addr_i = 32'h300; bus_req_ready_i = 1'b1;
        step();
        step();
        bus_req_ready_i = 1'b0;
        check("t6_err_before", 32'(err_o), 32'd0);
        for (int i = 0; i < 7; i++) begin
            step();
            check("t6_no_resp_yet", 32'(dmem_resp_v_o), 32'd0);
        end
        step();
        dmem_r_v_i = 1'b0;
        check("t6_resp_v", 32'(dmem_resp_v_o), 32'd1);
        check("t6_rdata", dmem_rdata_o, 32'hDEADBEEF);
        check("t6_err", 32'(err_o), 32'd1);
        step();
        dmem_r_v_i = 1'b1; dmem_addr_i = 32'h304; bus_req_ready_i = 1'b1;
        step();
        step();
        bus_req_ready_i = 1'b0; bus_resp_v_i = 1'b1; bus_rdata_i = 32'h13572468;
        step();
        bus_resp_v_i = 1'b0; dmem_r_v_i = 1'b0;
        check("t6_next_rdata", dmem_rdata_o, 32'h13572468);
        check("t6_err_sticky", 32'(err_o), 32'd1);
        step();
`else
        check("err_tied_low", 32'(err_o), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
